freq_meter: RTL
===============

# freq_meter

Measures the frequency of a slow, asynchronous square wave by counting its rising edges over a programmable gate window of `clk` cycles. It is the measuring counterpart to the team's clock dividers. A divider output, or any external pulse source, is fed to `sig_in`, and the result is reported as an edge count with a one-cycle `done` strobe. It sits beside the divider in lab top-levels so that divided clocks can be checked on the board and in simulation.

## Interface
- `GATE_W`, default 27: width of the gate-length input. Default covers windows up to ~1.34 s at 100 MHz.
- `CNT_W`, default 32: width of the edge counter and result.
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request a measurement. Sampled only in IDLE.
- `cont`, input, 1: continuous mode. When high, the block re-arms automatically after each DONE.
- `gate_len`, input, `GATE_W`: window length in `clk` cycles. Captured on the cycle `start` is accepted.
- `sig_in`, input, 1: asynchronous signal to measure.
- `busy`, output, 1: high in MEASURE and DONE.
- `done`, output, 1: one-cycle pulse when `edge_count` updates.
- `edge_count`, output, `CNT_W`: rising edges counted in the last completed window. Held until the next `done`.
- `overflow`, output, 1: the last window saturated the counter. Updated together with `edge_count`.

## Operation
- **Input path:** `sig_in` passes through a 2-FF synchronizer, then a third register. A rising edge is `s2 & ~s3`, giving a one-cycle `rise` pulse.
- **States:** IDLE, MEASURE, DONE.
- **IDLE:**
  - On `start=1`: latch `gate_len` into `gate_r`, clear the window counter and edge accumulator, go to MEASURE.
  - If `gate_len==0`: go directly to DONE with accumulator 0.
- **MEASURE:**
  - The window counter increments each cycle.
  - The accumulator increments on each `rise`, saturating at all-ones; the sticky `sat` flag is set when an increment is lost.
  - When the window counter reaches `gate_r-1`, that cycle's `rise` is still counted and the next state is DONE.
  - `start` is ignored in MEASURE.
- **DONE (one cycle):**
  - `edge_count <= acc`, `overflow <= sat`, `done=1`.
  - Next state is MEASURE if `cont=1` (reusing `gate_r` with counters cleared), else IDLE.
  - `start` is ignored in DONE.
- **Window definition:** exactly `gate_r` consecutive cycles of `rise` are sampled. A `rise` in the DONE cycle is never counted.
- **Reset (any time, including mid-window):**
  - All state returns to IDLE.
  - `busy=0`, `done=0`, `edge_count=0`, `overflow=0`.
  - Synchronizer FFs, `gate_r`, accumulator and `sat` are all cleared to 0.
  - A measurement cut off by reset produces no result.
- **Width rules:**
  - The window counter is `GATE_W` bits and never wraps, because it stops at `gate_r-1`.
  - The accumulator is `CNT_W` bits, unsigned, saturating and never wrapping.

## Timing
- `sig_in` rising edge to `rise` pulse: 3 `clk` edges. Edges within 3 cycles of window open or close may fall on either side of the boundary. Accuracy is ±1 count.
- `start` accepted at cycle t:
  - MEASURE covers cycles t+1 … t+`gate_len`.
  - DONE is at t+`gate_len`+1, where `done`=1 and the new `edge_count`/`overflow` are valid.
- `gate_len==0`: DONE is at t+1.
- `busy` rises at t+1 and falls after the DONE cycle, unless `cont` is set.
- Continuous mode: back-to-back windows are separated by exactly one DONE cycle.
- Input constraints: maximum countable `sig_in` frequency is `clk`/2, with high and low each ≥1 `clk` period. Faster inputs alias and are not flagged.

## Structure
- Shared package `freq_meter_pkg` holds:
  - state encoding constants `ST_IDLE=2'd0`, `ST_MEAS=2'd1`, `ST_DONE=2'd2`;
  - the default `GATE_W`/`CNT_W` values.
- Sub-module `edge_sync`: 2-FF synchronizer plus rise detector (`clk`, `rst_n`, `d`, `rise`). It is reusable for buttons and external inputs.
- The top module holds the FSM, window counter, accumulator and result registers.

## Test plan
- **Basic count:** `sig_in` toggles every 4 `clk` (period 8), starting aligned; `start` with `gate_len=800` → `done` at start+801, `edge_count=100`, `overflow=0`.
- **Zero and one window:**
  - `gate_len=0` → `done` 1 cycle after `start`, `edge_count=0`.
  - `gate_len=1` with a `rise` landing in that cycle → `edge_count=1`.
- **Saturation:** `CNT_W=4`, `sig_in` period 2, `gate_len=100` → `edge_count=15`, `overflow=1`. The next window with `sig_in` static → `edge_count=0`, `overflow=0`.
- **Continuous mode:** `cont=1`, `gate_len=50`, period-10 input → `done` pulses every 51 cycles, each `edge_count=5` (±1 at boundaries). `start` pulses during MEASURE are ignored.
- **Reset mid-window:** assert `rst_n=0` for 2 cycles at window cycle 30 of 100 → all outputs 0 immediately, no `done`, state IDLE. A subsequent `start` measures normally.
- **Divider loopback:** team divider output drives `sig_in` with an 8-cycle period, `gate_len=1024` → `edge_count` within 1 of 128.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and default widths for the frequency meter
package freq_meter_pkg;
  localparam int GATE_W_DEF = 27;
  localparam int CNT_W_DEF  = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-FF synchronizer plus one-cycle rising-edge detector
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] s_q;
  // shift the async input through two sync stages and one history stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= 3'b000;
    else        s_q <= {s_q[1:0], d};
  assign rise = s_q[1] & ~s_q[2];
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an async signal over a programmable gate window
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_W = GATE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              sig_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  edge_count,
  output logic              overflow
);
  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_q, gate_d, win_q, win_d;
  logic [CNT_W-1:0]   acc_q, acc_d, cnt_q, cnt_d;
  logic               sat_q, sat_d, ovf_q, ovf_d;
  logic               rise;

  edge_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .rise (rise)
  );

  // state, window, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end

  // next state; the result is loaded on entry to DONE so it is valid while done is high
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    win_d   = win_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE:
        if (start) begin
          gate_d  = gate_len;
          win_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = (gate_len == '0) ? ST_DONE : ST_MEAS;
          if (gate_len == '0) begin
            cnt_d = '0;
            ovf_d = 1'b0;
          end
        end
      ST_MEAS: begin
        win_d = win_q + GATE_W'(1);
        if (rise) begin
          if (&acc_q) sat_d = 1'b1;
          else        acc_d = acc_q + CNT_W'(1);
        end
        if (win_q == gate_q - GATE_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = acc_d;
          ovf_d   = sat_d;
        end
      end
      ST_DONE: begin
        win_d   = '0;
        acc_d   = '0;
        sat_d   = 1'b0;
        state_d = cont ? ST_MEAS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = state_q != ST_IDLE;
  assign done       = state_q == ST_DONE;
  assign edge_count = cnt_q;
  assign overflow   = ovf_q;
endmodule
